// File: rtl/ysyx_pkg.sv
// Shared types and constants for the core-side memory arbiter.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

package ysyx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      IF_AR,
      IF_R,
      LS_AR,
      LS_R,
      LS_W,
      LS_B
   } arb_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_arb_prio.sv
// IFU/LSU grant selection: LSU wins by default, the IFU wins once it has
// lost STARVE_MAX consecutive arbitration rounds.
module ysyx_arb_prio #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic ifu_req,
   input  logic lsu_req,
   output logic grant_ifu,
   output logic grant_lsu
);

   logic [3:0] starve_cnt;
   logic       ifu_forced;

   always_comb begin
      ifu_forced = ifu_req && (starve_cnt == 4'(STARVE_MAX));
      grant_lsu  = lsu_req && !ifu_forced;
      grant_ifu  = ifu_req && !grant_lsu;
   end

   // Only arbitration rounds taken in IDLE count as IFU losses.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (arb_en) begin
         if (grant_ifu)
            starve_cnt <= '0;
         else if (ifu_req && (starve_cnt != 4'hF))
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Shares one AXI-lite-style memory port between instruction fetch and the
// load/store path; one transaction at a time, IDLE between transactions.
module ysyx_mem_arbiter
   import ysyx_pkg::*;
#(
   parameter int unsigned BIT_W      = `YSYX_W_WIDTH,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifu_avalid,
   input  logic [BIT_W-1:0] ifu_addr,
   output logic [BIT_W-1:0] ifu_rdata,
   output logic             ifu_rvalid,
   input  logic             lsu_avalid,
   input  logic             lsu_ren,
   input  logic             lsu_wen,
   input  logic [BIT_W-1:0] lsu_addr,
   input  logic [BIT_W-1:0] lsu_wdata,
   input  logic [3:0]       lsu_wstrb,
   output logic [BIT_W-1:0] lsu_rdata,
   output logic             lsu_rvalid,
   output logic             lsu_wready,
   output logic             bus_arvalid,
   input  logic             bus_arready,
   output logic [BIT_W-1:0] bus_araddr,
   input  logic             bus_rvalid,
   input  logic [BIT_W-1:0] bus_rdata,
   input  logic [1:0]       bus_rresp,
   output logic             bus_rready,
   output logic             bus_awvalid,
   input  logic             bus_awready,
   output logic [BIT_W-1:0] bus_awaddr,
   output logic             bus_wvalid,
   input  logic             bus_wready,
   output logic [BIT_W-1:0] bus_wdata,
   output logic [3:0]       bus_wstrb,
   input  logic             bus_bvalid,
   input  logic [1:0]       bus_bresp,
   output logic             bus_bready,
   output logic             fault_o
);

   arb_state_e       state, state_nx;
   logic [BIT_W-1:0] addr_q, wdata_q;
   logic [3:0]       wstrb_q;
   logic             aw_done_q, w_done_q;
   logic             aw_hs, w_hs;
   logic             grant_ifu, grant_lsu;

   // Any LSU request without wen takes the read path, so ren carries no extra information.
   logic unused_ok;
   assign unused_ok = lsu_ren;

   ysyx_arb_prio #(
      .STARVE_MAX(STARVE_MAX)
   ) u_prio (
      .clk       (clk),
      .rst       (rst),
      .arb_en    (state == IDLE),
      .ifu_req   (ifu_avalid),
      .lsu_req   (lsu_avalid),
      .grant_ifu (grant_ifu),
      .grant_lsu (grant_lsu)
   );

   assign aw_hs      = bus_awvalid && bus_awready;
   assign w_hs       = bus_wvalid && bus_wready;
   assign bus_araddr = addr_q;
   assign bus_awaddr = addr_q;
   assign bus_wdata  = wdata_q;
   assign bus_wstrb  = wstrb_q;
   assign ifu_rdata  = bus_rdata;
   assign lsu_rdata  = bus_rdata;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else if (state == IDLE) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         if (grant_lsu) begin
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
            wstrb_q <= lsu_wstrb;
         end else if (grant_ifu) begin
            addr_q  <= ifu_addr;
         end
      end else if (state == LS_W) begin
         aw_done_q <= aw_done_q | aw_hs;
         w_done_q  <= w_done_q | w_hs;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (grant_lsu)      state_nx = lsu_wen ? LS_W : LS_AR;
            else if (grant_ifu) state_nx = IF_AR;
         end
         IF_AR: if (bus_arready) state_nx = IF_R;
         IF_R:  if (bus_rvalid)  state_nx = IDLE;
         LS_AR: if (bus_arready) state_nx = LS_R;
         LS_R:  if (bus_rvalid)  state_nx = IDLE;
         // Either handshake may land first or both in the same cycle.
         LS_W:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_nx = LS_B;
         LS_B:  if (bus_bvalid)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus_arvalid = 1'b0;
      bus_rready  = 1'b0;
      bus_awvalid = 1'b0;
      bus_wvalid  = 1'b0;
      bus_bready  = 1'b0;
      ifu_rvalid  = 1'b0;
      lsu_rvalid  = 1'b0;
      lsu_wready  = 1'b0;
      fault_o     = 1'b0;
      unique case (state)
         IF_AR, LS_AR: bus_arvalid = 1'b1;
         IF_R: begin
            bus_rready = 1'b1;
            ifu_rvalid = bus_rvalid;
            fault_o    = bus_rvalid && (bus_rresp != RESP_OKAY);
         end
         LS_R: begin
            bus_rready = 1'b1;
            lsu_rvalid = bus_rvalid;
            fault_o    = bus_rvalid && (bus_rresp != RESP_OKAY);
         end
         LS_W: begin
            bus_awvalid = !aw_done_q;
            bus_wvalid  = !w_done_q;
         end
         LS_B: begin
            bus_bready = 1'b1;
            lsu_wready = bus_bvalid;
            fault_o    = bus_bvalid && (bus_bresp != RESP_OKAY);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Scoreboarded bench for ysyx_mem_arbiter: directed requester stimulus, a
// configurable bus slave model, and a monitor that checks every completion.
module tb_ysyx_mem_arbiter;
   import ysyx_pkg::*;

   logic        clk, rst;
   logic        ifu_avalid, ifu_rvalid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_avalid, lsu_ren, lsu_wen, lsu_rvalid, lsu_wready;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wstrb;
   logic        bus_arvalid, bus_arready, bus_rvalid, bus_rready;
   logic [31:0] bus_araddr, bus_rdata, bus_awaddr, bus_wdata;
   logic [1:0]  bus_rresp, bus_bresp;
   logic        bus_awvalid, bus_awready, bus_wvalid, bus_wready, bus_bvalid, bus_bready;
   logic [3:0]  bus_wstrb;
   logic        fault_o;

   ysyx_mem_arbiter #(.BIT_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_avalid(ifu_avalid), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
      .lsu_avalid(lsu_avalid), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_rdata(lsu_rdata),
      .lsu_rvalid(lsu_rvalid), .lsu_wready(lsu_wready),
      .bus_arvalid(bus_arvalid), .bus_arready(bus_arready), .bus_araddr(bus_araddr),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rresp(bus_rresp), .bus_rready(bus_rready),
      .bus_awvalid(bus_awvalid), .bus_awready(bus_awready), .bus_awaddr(bus_awaddr),
      .bus_wvalid(bus_wvalid), .bus_wready(bus_wready), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_bvalid(bus_bvalid), .bus_bresp(bus_bresp), .bus_bready(bus_bready),
      .fault_o(fault_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model configuration; read data is either a fixed word or address+1.
   int unsigned ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
   logic        data_mode = 1'b0;
   logic [31:0] rd_val = '0;
   logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
   logic        force_rvalid = 1'b0;

   int unsigned ar_cnt, aw_cnt, w_cnt, r_cnt;
   logic        r_pending, aw_got, w_got;
   logic [31:0] r_addr;
   logic        s_rvalid;

   assign bus_arready = bus_arvalid && (ar_cnt >= ar_delay);
   assign bus_awready = bus_awvalid && (aw_cnt >= aw_delay);
   assign bus_wready  = bus_wvalid && (w_cnt >= w_delay);
   assign s_rvalid    = r_pending && (r_cnt >= r_delay);
   assign bus_rvalid  = s_rvalid || force_rvalid;
   assign bus_rdata   = data_mode ? r_addr + 32'd1 : rd_val;
   assign bus_rresp   = rresp_cfg;
   assign bus_bvalid  = aw_got && w_got;
   assign bus_bresp   = bresp_cfg;

   always @(posedge clk) begin
      if (rst) begin
         ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
         r_pending <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; r_addr <= '0;
      end else begin
         ar_cnt <= (bus_arvalid && !bus_arready) ? ar_cnt + 1 : 0;
         aw_cnt <= (bus_awvalid && !bus_awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (bus_wvalid && !bus_wready) ? w_cnt + 1 : 0;
         if (bus_arvalid && bus_arready) begin
            r_pending <= 1'b1; r_addr <= bus_araddr; r_cnt <= 0;
         end else if (s_rvalid && bus_rready) begin
            r_pending <= 1'b0;
         end else if (r_pending) begin
            r_cnt <= r_cnt + 1;
         end
         if (bus_bvalid && bus_bready) begin
            aw_got <= 1'b0; w_got <= 1'b0;
         end else begin
            if (bus_awvalid && bus_awready) aw_got <= 1'b1;
            if (bus_wvalid && bus_wready)   w_got  <= 1'b1;
         end
      end
   end

   // kind: 0 = IFU read, 1 = LSU read, 2 = LSU write
   typedef struct {
      int          kind;
      logic [31:0] data;
      logic        fault;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push(input int kind, input logic [31:0] d, input logic f, input int c);
      exp_t e;
      e.kind = kind; e.data = d; e.fault = f; e.cyc = c;
      sb.push_back(e);
   endfunction

   task automatic handle(input int kind, input logic [31:0] data);
      exp_t e;
      if (sb.size() == 0) begin
         chk("unexpected_pulse", 32'(kind), 32'hFFFF_FFFF);
      end else begin
         e = sb.pop_front();
         chk("pulse_kind", 32'(kind), 32'(e.kind));
         if (kind != 2) chk("rdata", data, e.data);
         chk("fault", 32'(fault_o), 32'(e.fault));
         chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
   endtask

   always @(negedge clk) begin
      if (ifu_rvalid) handle(0, ifu_rdata);
      if (lsu_rvalid) handle(1, lsu_rdata);
      if (lsu_wready) handle(2, 32'h0);
      if (fault_o && !(ifu_rvalid || lsu_rvalid || lsu_wready))
         chk("fault_without_pulse", 32'(fault_o), 32'h0);
   end

   task automatic drive_at(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_cycle(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   initial begin
      rst = 1'b1;
      ifu_avalid = 1'b1; ifu_addr = 32'h8000_0100;
      lsu_avalid = 1'b1; lsu_ren = 1'b1; lsu_wen = 1'b0;
      lsu_addr = 32'h2000_0040; lsu_wdata = '0; lsu_wstrb = '0;
      data_mode = 1'b1;

      // Reset with both requesters active: nothing may start.
      at_cycle(1);
      chk("rst_arvalid", 32'(bus_arvalid), 32'h0);
      chk("rst_awvalid", 32'(bus_awvalid), 32'h0);
      chk("rst_wvalid",  32'(bus_wvalid),  32'h0);
      chk("rst_araddr",  bus_araddr,       32'h0);
      chk("rst_state",   32'(dut.state),   32'(IDLE));
      chk("rst_starve",  32'(dut.u_prio.starve_cnt), 32'h0);
      drive_at(2);
      rst = 1'b0;
      push(1, 32'h2000_0041, 1'b0, 4);
      push(0, 32'h8000_0101, 1'b0, 7);
      at_cycle(2);
      chk("first_idle_arvalid", 32'(bus_arvalid), 32'h0);
      at_cycle(3);
      chk("lsu_first_arvalid", 32'(bus_arvalid), 32'h1);
      chk("lsu_first_araddr",  bus_araddr,       32'h2000_0040);
      drive_at(5);
      lsu_avalid = 1'b0;
      at_cycle(5);
      chk("starve_after_loss", 32'(dut.u_prio.starve_cnt), 32'h1);
      drive_at(8);
      ifu_avalid = 1'b0;
      at_cycle(8);
      chk("starve_after_ifu", 32'(dut.u_prio.starve_cnt), 32'h0);

      // Single zero-wait fetch.
      drive_at(10);
      data_mode = 1'b0; rd_val = 32'h0000_0413;
      ifu_addr = 32'h8000_0000; ifu_avalid = 1'b1;
      push(0, 32'h0000_0413, 1'b0, 12);
      at_cycle(11);
      chk("fetch_arvalid", 32'(bus_arvalid), 32'h1);
      chk("fetch_araddr",  bus_araddr,       32'h8000_0000);
      drive_at(13);
      ifu_avalid = 1'b0;

      // Store with awready held off two cycles, wready immediate.
      drive_at(15);
      aw_delay = 2;
      lsu_avalid = 1'b1; lsu_wen = 1'b1; lsu_ren = 1'b0;
      lsu_addr = 32'hA000_03F8; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
      push(2, 32'h0, 1'b0, 19);
      at_cycle(16);
      chk("st_c1_awvalid", 32'(bus_awvalid), 32'h1);
      chk("st_c1_wvalid",  32'(bus_wvalid),  32'h1);
      chk("st_awaddr",     bus_awaddr,       32'hA000_03F8);
      chk("st_wdata",      bus_wdata,        32'hDEAD_BEEF);
      chk("st_wstrb",      32'(bus_wstrb),   32'hF);
      at_cycle(17);
      chk("st_c2_awvalid", 32'(bus_awvalid), 32'h1);
      chk("st_c2_wvalid",  32'(bus_wvalid),  32'h0);
      at_cycle(18);
      chk("st_c3_awvalid", 32'(bus_awvalid), 32'h1);
      chk("st_c3_wvalid",  32'(bus_wvalid),  32'h0);
      at_cycle(19);
      chk("st_c4_awvalid", 32'(bus_awvalid), 32'h0);
      chk("st_c4_bready",  32'(bus_bready),  32'h1);
      drive_at(20);
      lsu_avalid = 1'b0; lsu_wen = 1'b0; aw_delay = 0;

      // Load answered with SLVERR.
      drive_at(22);
      rresp_cfg = 2'b10; rd_val = 32'h1234_5678;
      lsu_avalid = 1'b1; lsu_ren = 1'b1; lsu_addr = 32'h2000_0080;
      push(1, 32'h1234_5678, 1'b1, 24);
      drive_at(25);
      lsu_avalid = 1'b0; rresp_cfg = 2'b00;
      at_cycle(25);
      chk("err_after_fault",  32'(fault_o),   32'h0);
      chk("err_after_rready", 32'(bus_rready), 32'h0);
      chk("err_after_state",  32'(dut.state), 32'(IDLE));

      // Continuous contention: four LSU grants then one forced IFU grant.
      drive_at(27);
      data_mode = 1'b1;
      ifu_addr = 32'h8000_0100; lsu_addr = 32'h2000_0040;
      ifu_avalid = 1'b1; lsu_avalid = 1'b1; lsu_ren = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k % 5 == 4) push(0, 32'h8000_0101, 1'b0, 29 + 3 * k);
         else            push(1, 32'h2000_0041, 1'b0, 29 + 3 * k);
      end
      at_cycle(39);
      chk("starve_at_limit", 32'(dut.u_prio.starve_cnt), 32'h4);
      at_cycle(40);
      chk("starve_cleared",  32'(dut.u_prio.starve_cnt), 32'h0);
      drive_at(57);
      ifu_avalid = 1'b0; lsu_avalid = 1'b0;

      // Reset while waiting for read data; a late rvalid must be ignored.
      drive_at(59);
      data_mode = 1'b0; rd_val = 32'hCAFE_F00D; r_delay = 5;
      lsu_avalid = 1'b1; lsu_ren = 1'b1; lsu_addr = 32'h2000_00C0;
      drive_at(61);
      rst = 1'b1; lsu_avalid = 1'b0;
      at_cycle(61);
      chk("lsr_rready", 32'(bus_rready), 32'h1);
      drive_at(62);
      rst = 1'b0; force_rvalid = 1'b1; r_delay = 0;
      at_cycle(62);
      chk("lsr_rst_state",  32'(dut.state),   32'(IDLE));
      chk("lsr_rst_rready", 32'(bus_rready),  32'h0);
      chk("lsr_no_pulse",   32'(lsu_rvalid),  32'h0);
      at_cycle(63);
      chk("lsr_no_pulse2",  32'(lsu_rvalid),  32'h0);
      drive_at(64);
      force_rvalid = 1'b0;

      at_cycle(67);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
